// File: rtl/input_port_ctrl.sv
// Router input-port controller.
// It latches the destination of each header flit and asks the arbiter for a
// route. A deny or a timeout causes a back-off and a retry. A grant moves the
// port through PRELOCK and LOCK while the crossbar sends pack, suspend and
// cancel. The data, strobe and forward-control paths pass straight through;
// only the forward control is gated while the port is suspended.
module input_port_ctrl #(
    parameter logic [3:0] LOCAL_Y   = 4'b0010,
    parameter logic [3:0] LOCAL_X   = 4'b0010,
    parameter int         DATAW     = 32'd66,
    parameter int         ADDRYX    = 32'd8,
    parameter int         BWCTRLW   = 32'd3,
    parameter int         MAX_RETRY = 32'd3,
    parameter int         BACKOFF   = 32'd4,
    parameter int         TIMEOUT   = 32'd16,
    localparam int        RETRYW    = (MAX_RETRY < 32'd1) ? 32'd1 : $clog2(MAX_RETRY + 32'd1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               input_stb_i,
    input  logic               input_fwd_i,
    input  logic               input_grant_i,
    input  logic               input_deny_i,
    input  logic [BWCTRLW-1:0] input_bwctrl_i,
    input  logic [DATAW-1:0]   input_data_i,
    output logic               input_stb_o,
    output logic               input_fwd_o,
    output logic [DATAW-1:0]   input_data_o,
    output logic               input_request_o,
    output logic [ADDRYX-1:0]  input_address_o,
    output logic               input_local_o,
    output logic               input_pack_o,
    output logic               input_suspend_o,
    output logic               input_cancel_o,
    output logic               input_fail_o,
    output logic [RETRYW-1:0]  input_retry_o
);

    // One shared counter serves both the REQ timeout and the BACKOFF length.
    // The two phases never overlap, and the counter clears on every state change.
    localparam int MAXC = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
    localparam int CNTW = $clog2(MAXC + 32'd1);

    localparam logic [ADDRYX-1:0] LOCAL_ADDR = ADDRYX'({LOCAL_Y, LOCAL_X});
    localparam logic [CNTW-1:0]   TIMEOUT_LAST = CNTW'(TIMEOUT - 32'd1);
    localparam logic [CNTW-1:0]   BACKOFF_LAST = CNTW'(BACKOFF - 32'd1);
    localparam logic [RETRYW-1:0] RETRY_MAX    = RETRYW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_BACKOFF = 3'd2,
        ST_PRELOCK = 3'd3,
        ST_LOCK    = 3'd4,
        ST_SUSP    = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNTW-1:0]     cnt_r;
    logic [RETRYW-1:0]   retry_r;
    logic [ADDRYX-1:0]   address_r;
    logic                local_r;
    logic                request_r;
    logic                fail_r;
    logic                pack_r;
    logic                suspend_r;
    logic                cancel_r;
    logic                deny_eff_s;
    logic                bw_pack_s;
    logic                bw_suspend_s;
    logic                bw_cancel_s;

    assign bw_pack_s    = input_bwctrl_i[0];
    assign bw_suspend_s = input_bwctrl_i[1];
    assign bw_cancel_s  = input_bwctrl_i[2];

    // A REQ cycle that reaches the timeout is treated exactly like an arbiter deny.
    assign deny_eff_s = input_deny_i || (cnt_r == TIMEOUT_LAST);

    // Next-state decode; a dropped link outside IDLE overrides every other condition.
    always_comb begin
        state_nxt_s = state_r;
        if ((state_r != ST_IDLE) && !input_stb_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (input_stb_i && input_data_i[DATAW-1]) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (deny_eff_s) begin
                        if (retry_r < RETRY_MAX) begin
                            state_nxt_s = ST_BACKOFF;
                        end else begin
                            state_nxt_s = ST_FAIL;
                        end
                    end else if (input_grant_i) begin
                        state_nxt_s = ST_PRELOCK;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_BACKOFF: begin
                    if (cnt_r == BACKOFF_LAST) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_BACKOFF;
                    end
                end
                ST_PRELOCK: begin
                    if (input_deny_i) begin
                        state_nxt_s = ST_FAIL;
                    end else if (bw_pack_s) begin
                        state_nxt_s = ST_LOCK;
                    end else begin
                        state_nxt_s = ST_PRELOCK;
                    end
                end
                ST_LOCK: begin
                    if (input_deny_i) begin
                        state_nxt_s = ST_FAIL;
                    end else if (bw_cancel_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (bw_suspend_s) begin
                        state_nxt_s = ST_SUSP;
                    end else begin
                        state_nxt_s = ST_LOCK;
                    end
                end
                ST_SUSP: begin
                    if (bw_cancel_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (!bw_suspend_s) begin
                        state_nxt_s = ST_LOCK;
                    end else begin
                        state_nxt_s = ST_SUSP;
                    end
                end
                ST_FAIL: begin
                    state_nxt_s = ST_FAIL;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and all registered outputs; outputs follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            retry_r   <= '0;
            address_r <= '0;
            local_r   <= 1'b0;
            request_r <= 1'b0;
            fail_r    <= 1'b0;
            pack_r    <= 1'b0;
            suspend_r <= 1'b0;
            cancel_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            request_r <= (state_nxt_s == ST_REQ);
            fail_r    <= (state_nxt_s == ST_FAIL) && (state_r != ST_FAIL);
            pack_r    <= bw_pack_s;
            suspend_r <= bw_suspend_s;
            cancel_r  <= bw_cancel_s;

            if (state_nxt_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == ST_REQ) || (state_r == ST_BACKOFF)) begin
                cnt_r <= cnt_r + CNTW'(1);
            end else begin
                cnt_r <= '0;
            end

            if (state_nxt_s == ST_IDLE) begin
                retry_r <= '0;
            end else if ((state_r == ST_REQ) && (state_nxt_s == ST_BACKOFF)) begin
                retry_r <= retry_r + RETRYW'(1);
            end else begin
                retry_r <= retry_r;
            end

            if (state_nxt_s == ST_IDLE) begin
                address_r <= '0;
                local_r   <= 1'b0;
            end else if (state_r == ST_IDLE) begin
                address_r <= input_data_i[2*ADDRYX-1:ADDRYX];
                local_r   <= (input_data_i[2*ADDRYX-1:ADDRYX] == LOCAL_ADDR);
            end else begin
                address_r <= address_r;
                local_r   <= local_r;
            end
        end
    end

    assign input_stb_o     = input_stb_i;
    assign input_data_o    = input_data_i;
    assign input_fwd_o     = input_fwd_i && (state_r != ST_SUSP);
    assign input_request_o = request_r;
    assign input_address_o = address_r;
    assign input_local_o   = local_r;
    assign input_pack_o    = pack_r;
    assign input_suspend_o = suspend_r;
    assign input_cancel_o  = cancel_r;
    assign input_fail_o    = fail_r;
    assign input_retry_o   = retry_r;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Scoreboard bench for input_port_ctrl.
// The driver applies one input vector per cycle on the falling edge. It steps
// a behavioural phase model and queues the expected outputs for the next
// rising edge. The monitor pops the queue just after each rising edge and
// compares the expected outputs with the DUT outputs.
module tb_input_port_ctrl;

    localparam int MAX_RETRY = 3;
    localparam int BACKOFF   = 4;
    localparam int TIMEOUT   = 16;

    logic        clk;
    logic        reset;
    logic        stb_i, fwd_i, grant_i, deny_i;
    logic [2:0]  bw_i;
    logic [65:0] data_i;
    logic        stb_o, fwd_o, request_o, local_o, pack_o, suspend_o, cancel_o, fail_o;
    logic [65:0] data_o;
    logic [7:0]  address_o;
    logic [1:0]  retry_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic rst_v;

    input_port_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .input_stb_i     (stb_i),
        .input_fwd_i     (fwd_i),
        .input_grant_i   (grant_i),
        .input_deny_i    (deny_i),
        .input_bwctrl_i  (bw_i),
        .input_data_i    (data_i),
        .input_stb_o     (stb_o),
        .input_fwd_o     (fwd_o),
        .input_data_o    (data_o),
        .input_request_o (request_o),
        .input_address_o (address_o),
        .input_local_o   (local_o),
        .input_pack_o    (pack_o),
        .input_suspend_o (suspend_o),
        .input_cancel_o  (cancel_o),
        .input_fail_o    (fail_o),
        .input_retry_o   (retry_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stb;
        logic        fwd;
        logic [65:0] data;
        logic        req;
        logic [7:0]  addr;
        logic        loc;
        logic        pk;
        logic        su;
        logic        ca;
        logic        fl;
        logic [1:0]  retry;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: the phase of the transaction plus counters for
    // cycles spent asking, back-off cycles remaining and retries used.
    typedef enum int {P_IDLE, P_ASK, P_PAUSE, P_WON, P_OWN, P_HELD, P_DEAD} ph_t;
    ph_t        ph = P_IDLE;
    int         asked = 0;
    int         pause_left = 0;
    int         tries = 0;
    logic [7:0] m_addr = 8'h00;

    task automatic model(input logic r, s, f, g, d, input logic [2:0] bw,
                         input logic [65:0] dat, output exp_t e);
        ph_t was;
        was = ph;
        if (!r) begin
            ph = P_IDLE; asked = 0; pause_left = 0; tries = 0; m_addr = 8'h00;
        end else if (ph != P_IDLE && !s) begin
            ph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE: if (s && dat[65]) begin ph = P_ASK; asked = 0; m_addr = dat[15:8]; end
                P_ASK: begin
                    asked++;
                    if (d || asked >= TIMEOUT) begin
                        if (tries < MAX_RETRY) begin
                            tries++; ph = P_PAUSE; pause_left = BACKOFF;
                        end else begin
                            ph = P_DEAD;
                        end
                    end else if (g) begin
                        ph = P_WON;
                    end
                end
                P_PAUSE: begin
                    pause_left--;
                    if (pause_left == 0) begin ph = P_ASK; asked = 0; end
                end
                P_WON:  if (d) ph = P_DEAD; else if (bw[0]) ph = P_OWN;
                P_OWN:  if (d) ph = P_DEAD; else if (bw[2]) ph = P_IDLE; else if (bw[1]) ph = P_HELD;
                P_HELD: if (bw[2]) ph = P_IDLE; else if (!bw[1]) ph = P_OWN;
                P_DEAD: ;
                default: ph = P_IDLE;
            endcase
        end
        if (ph == P_IDLE) begin tries = 0; m_addr = 8'h00; end
        e.stb   = s;
        e.data  = dat;
        e.fwd   = f && (ph != P_HELD);
        e.req   = (ph == P_ASK);
        e.addr  = m_addr;
        e.loc   = (ph != P_IDLE) && (m_addr == 8'h22);
        e.pk    = r && bw[0];
        e.su    = r && bw[1];
        e.ca    = r && bw[2];
        e.fl    = r && (ph == P_DEAD) && (was != P_DEAD);
        e.retry = 2'(tries);
    endtask

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exv);
        end
    endtask

    function automatic logic [65:0] rnd66();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[65:0];
    endfunction

    function automatic logic [65:0] hdr(input logic [7:0] a);
        logic [65:0] d;
        d = rnd66();
        d[65] = 1'b1;
        d[15:8] = a;
        return d;
    endfunction

    function automatic logic [65:0] body();
        logic [65:0] d;
        d = rnd66();
        d[65] = 1'b0;
        return d;
    endfunction

    // Driver: apply one cycle of stimulus and queue the expected response.
    task automatic cyc(input logic s, f, g, d, input logic [2:0] bw, input logic [65:0] dat);
        exp_t e;
        @(negedge clk);
        reset = rst_v; stb_i = s; fwd_i = f; grant_i = g; deny_i = d; bw_i = bw; data_i = dat;
        model(rst_v, s, f, g, d, bw, dat, e);
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs with the queued expectation after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stb_o",     80'(stb_o),     80'(e.stb));
                chk("fwd_o",     80'(fwd_o),     80'(e.fwd));
                chk("data_o",    80'(data_o),    80'(e.data));
                chk("request_o", 80'(request_o), 80'(e.req));
                chk("address_o", 80'(address_o), 80'(e.addr));
                chk("local_o",   80'(local_o),   80'(e.loc));
                chk("pack_o",    80'(pack_o),    80'(e.pk));
                chk("suspend_o", 80'(suspend_o), 80'(e.su));
                chk("cancel_o",  80'(cancel_o),  80'(e.ca));
                chk("fail_o",    80'(fail_o),    80'(e.fl));
                chk("retry_o",   80'(retry_o),   80'(e.retry));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        exp_t dummy;
        rst_v = 1'b0;
        reset = 1'b0; stb_i = 1'b0; fwd_i = 1'b0; grant_i = 1'b0; deny_i = 1'b0;
        bw_i = 3'b000; data_i = '0;
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, body());

        // Header on the first clock out of reset, grant after two request cycles, then pack.
        rst_v = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, hdr(8'h22));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, body());
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, body());
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, body());
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, body());

        // Every request denied: three back-offs, then fail.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, hdr(8'h31));
        repeat (24) cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, body());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, body());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, body());

        // Timeout, then grant and deny together, then a grant after back-off.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, hdr(8'h22));
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, body());
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, body());
        repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, body());

        // Lock, suspend for three cycles, resume, then cancel.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, body());
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, body());

        // Asynchronous reset asserted between edges while locked.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, hdr(8'h22));
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, body());
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, body());
        @(posedge clk);
        #3;
        rst_v = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_request", 80'(request_o), 80'(1'b0));
        chk("arst_address", 80'(address_o), 80'(8'h00));
        chk("arst_local",   80'(local_o),   80'(1'b0));
        chk("arst_pack",    80'(pack_o),    80'(1'b0));
        chk("arst_fail",    80'(fail_o),    80'(1'b0));
        chk("arst_fwd",     80'(fwd_o),     80'(fwd_i));
        model(1'b0, stb_i, fwd_i, grant_i, deny_i, bw_i, data_i, dummy);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, hdr(8'h22));
        rst_v = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, hdr(8'h13));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, body());

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic        s, f, g, d;
            logic [2:0]  bw;
            logic [65:0] dat;
            s   = ($urandom_range(0, 24) != 0);
            f   = 1'($urandom_range(0, 1));
            g   = ($urandom_range(0, 4) == 0);
            d   = ($urandom_range(0, 11) == 0);
            bw  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0)};
            dat = rnd66();
            dat[65] = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0: dat[15:8] = 8'h22;
                1: dat[15:8] = 8'h31;
                default: ;
            endcase
            cyc(s, f, g, d, bw, dat);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 80'(exp_q.size()), 80'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  LOCAL_Y  4'b0010  router Y coordinate
  LOCAL_X  4'b0010  router X coordinate
  DATAW  66  flit width; bit DATAW-1 is the header flag
  ADDRYX  8  destination address width; address is data bits [2*ADDRYX-1:ADDRYX]
  BWCTRLW  3  backward-control width; bit 0 pack, bit 1 suspend, bit 2 cancel
  MAX_RETRY  3  deny retries before failing; 0 means fail on first deny
  BACKOFF  4  idle cycles between deny and re-request (>=1)
  TIMEOUT  16  REQ cycles without grant/deny before treating as deny (>=1)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  input_stb_i  in  1  link held up by upstream
  input_fwd_i  in  1  upstream forward control
  input_grant_i  in  1  arbiter grant
  input_deny_i  in  1  arbiter deny
  input_bwctrl_i  in  BWCTRLW  crossbar pack/suspend/cancel
  input_data_i  in  DATAW  incoming flit
  input_stb_o  out  1  = input_stb_i (combinational)
  input_fwd_o  out  1  = input_fwd_i, forced 0 in SUSP
  input_data_o  out  DATAW  = input_data_i (combinational)
  input_request_o  out  1  arbitration request
  input_address_o  out  ADDRYX  latched destination
  input_local_o  out  1  latched destination equals {LOCAL_Y,LOCAL_X}
  input_pack_o / input_suspend_o / input_cancel_o  out  1 each  registered bwctrl bits
  input_fail_o  out  1  one-cycle failure pulse
  input_retry_o  out  clog2(MAX_RETRY+1), min 1  retries used

Function
REQ-003 States SHALL be IDLE, REQ, BACKOFF, PRELOCK, LOCK, SUSP, FAIL in a registered 3-bit state.
REQ-004 In every state except IDLE, input_stb_i=0 SHALL force IDLE next cycle, overriding all other conditions.
REQ-005 IDLE: input_stb_i=1 with input_data_i[DATAW-1]=1 SHALL move to REQ and latch the address field and local match on that edge.
REQ-006 Address and local flag SHALL hold from REQ until IDLE and read 0 in IDLE.
REQ-007 input_request_o SHALL be 1 exactly while state is REQ (first asserted the cycle after header).
REQ-008 REQ: deny, or timeout counter reaching TIMEOUT, SHALL count as a deny; deny wins over a simultaneous grant; otherwise grant moves to PRELOCK.
REQ-009 Deny in REQ: if retry count < MAX_RETRY, go to BACKOFF and increment retry count; else go to FAIL.
REQ-010 BACKOFF SHALL last exactly BACKOFF cycles, ignore grant/deny, then return to REQ with the timeout counter cleared.
REQ-011 PRELOCK: deny -> FAIL (no retry); bwctrl pack -> LOCK; else stay.
REQ-012 LOCK: deny -> FAIL; cancel -> IDLE; suspend -> SUSP; priority in that order.
REQ-013 SUSP: cancel -> IDLE; suspend cleared -> LOCK; input_fwd_o=0 throughout.
REQ-014 FAIL: remain until input_stb_i=0; input_fail_o SHALL pulse high exactly one cycle, the first FAIL cycle.
REQ-015 pack/suspend/cancel outputs SHALL be bwctrl bits delayed one clock, in all states.
REQ-016 Retry count SHALL clear on entry to IDLE and saturate at MAX_RETRY.

Reset
REQ-017 reset=0 SHALL immediately force IDLE, all counters 0, and every registered output 0, including mid-transfer; pass-through outputs keep following inputs.
REQ-018 First header is accepted on the first rising edge with reset=1.

Verification
REQ-019 Header data[65]=1, address 8'h22, grant 2 cycles later, pack 1 cycle later -> REQ, PRELOCK, LOCK; local_o=1, address_o=8'h22, request_o high 2 cycles.
REQ-020 Header addr 8'h31, deny every request -> 3 BACKOFF periods of 4 cycles, retry_o 1..3, 4th deny -> FAIL, fail_o one pulse; stb_i=0 -> IDLE, retry_o=0.
REQ-021 No grant/deny for 16 REQ cycles -> BACKOFF, retry_o=1; grant and deny same cycle -> deny wins.
REQ-022 LOCK, suspend=1 for 3 cycles with fwd_i=1 -> SUSP, fwd_o=0 for 3 cycles, suspend_o delayed 1 cycle; suspend=0 -> LOCK; cancel=1 -> IDLE.
REQ-023 reset driven low in LOCK between clock edges -> request_o, fail_o, address_o, state cleared immediately, before next edge.
